// File: rtl/sad_accumulator_if.sv
// Stream/result bundle between the pixel source, the SAD accumulator and the
// min-SAD comparator that consumes its results.
interface sad_accumulator_if #(
    parameter int PIX_W = 8
);
    logic             Start;
    logic [7:0]       CandRow;
    logic [7:0]       CandColumn;
    logic             PixValid;
    logic             PixReady;
    logic [PIX_W-1:0] CurPixel;
    logic [PIX_W-1:0] RefPixel;
    logic [31:0]      SAD;
    logic [7:0]       SADRow;
    logic [7:0]       SADColumn;
    logic             SADValid;
    logic             SADReady;
    logic             Busy;

    // Driver side: issues candidates, streams pixel pairs and accepts results.
    modport master (
        output Start, CandRow, CandColumn, PixValid, CurPixel, RefPixel, SADReady,
        input  PixReady, SAD, SADRow, SADColumn, SADValid, Busy
    );

    // Accumulator side.
    modport slave (
        input  Start, CandRow, CandColumn, PixValid, CurPixel, RefPixel, SADReady,
        output PixReady, SAD, SADRow, SADColumn, SADValid, Busy
    );
endinterface

// File: rtl/sad_accumulator.sv
// Sum of absolute differences between a current-frame block and one candidate
// reference block. Pixel pairs stream in; the final sum plus the candidate's
// row/column tags are held until the downstream comparator accepts them.
module sad_accumulator #(
    parameter int BLOCK_W = 4,
    parameter int BLOCK_H = 4,
    parameter int PIX_W   = 8
) (
    input logic               Clk,
    input logic               Rst_n,
    sad_accumulator_if.slave  bus
);

    localparam int N     = BLOCK_W * BLOCK_H;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [31:0]      acc_q,     acc_d;
    logic [7:0]       candRow_q, candRow_d;
    logic [7:0]       candCol_q, candCol_d;
    logic [31:0]      sad_q,     sad_d;
    logic [7:0]       sadRow_q,  sadRow_d;
    logic [7:0]       sadCol_q,  sadCol_d;

    logic [PIX_W-1:0] diff;
    logic [31:0]      diffExt;

    // State register plus all datapath registers; reset discards any partial candidate.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            candRow_q <= '0;
            candCol_q <= '0;
            sad_q     <= '0;
            sadRow_q  <= '0;
            sadCol_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            candRow_q <= candRow_d;
            candCol_q <= candCol_d;
            sad_q     <= sad_d;
            sadRow_q  <= sadRow_d;
            sadCol_q  <= sadCol_d;
        end
    end

    // Absolute difference of the current pair, zero-extended to the accumulator width.
    always_comb begin
        diff    = (bus.CurPixel >= bus.RefPixel) ? (bus.CurPixel - bus.RefPixel)
                                                 : (bus.RefPixel - bus.CurPixel);
        diffExt = 32'(diff);
    end

    // Next-state and datapath updates; the published result only changes on the last pair.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        candRow_d = candRow_q;
        candCol_d = candCol_q;
        sad_d     = sad_q;
        sadRow_d  = sadRow_q;
        sadCol_d  = sadCol_q;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    candRow_d = bus.CandRow;
                    candCol_d = bus.CandColumn;
                    acc_d     = '0;
                    count_d   = '0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.PixValid) begin
                    acc_d   = acc_q + diffExt;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        sad_d    = acc_q + diffExt;
                        sadRow_d = candRow_q;
                        sadCol_d = candCol_q;
                        count_d  = '0;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.SADReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.PixReady  = (state_q == ACCUM);
    assign bus.SADValid  = (state_q == DONE);
    assign bus.Busy      = (state_q != IDLE);
    assign bus.SAD       = sad_q;
    assign bus.SADRow    = sadRow_q;
    assign bus.SADColumn = sadCol_q;

endmodule

// File: tb/tb_sad_accumulator.sv
// Bench for sad_accumulator: table of candidates streamed through the block,
// expected results queued at Start and checked when the result is accepted.
module tb_sad_accumulator;

    localparam int N     = 16;
    localparam int GUARD = 200;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    always #5 Clk = ~Clk;

    sad_accumulator_if #(.PIX_W(8)) bus ();

    sad_accumulator #(
        .BLOCK_W(4),
        .BLOCK_H(4),
        .PIX_W  (8)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0]  row;
        logic [7:0]  col;
        logic [7:0]  cur;
        logic [7:0]  ref_;
        logic [7:0]  step;
        bit          gap;
        int          hold;
        bit          pulse;
        logic [31:0] expSad;
        int          expLat;
    } vec_t;

    typedef struct {
        logic [31:0] sad;
        logic [7:0]  row;
        logic [7:0]  col;
    } exp_t;

    exp_t        sbQ[$];
    vec_t        tbl[6];
    int          vecCount  = 0;
    int          missCount = 0;
    logic [31:0] lastSad   = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Result monitor: whenever a result is handed over, pop and compare the scoreboard.
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Rst_n && bus.SADValid && bus.SADReady) begin
            if (sbQ.size() == 0) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL extraResult: got SAD=%0d, expected no result", bus.SAD);
            end else begin
                e = sbQ.pop_front();
                checkOutput("resultSad", bus.SAD, e.sad);
                checkOutput("resultRow", 32'(bus.SADRow), 32'(e.row));
                checkOutput("resultCol", 32'(bus.SADColumn), 32'(e.col));
            end
        end
    end

    // Runs one candidate from Start to result acceptance; optionally resets after some pairs.
    task automatic applyStimulus(input vec_t v, input int resetAfter);
        int  accepted;
        int  cyc;
        int  guard;
        bit  phase;
        accepted = 0;
        guard    = 0;
        phase    = 1'b0;

        bus.Start      = 1'b1;
        bus.CandRow    = v.row;
        bus.CandColumn = v.col;
        sbQ.push_back('{v.expSad, v.row, v.col});
        tick();
        cyc = 1;
        bus.Start      = 1'b0;
        bus.CandRow    = 8'hAA;
        bus.CandColumn = 8'h55;
        checkOutput("busyInAccum", 32'(bus.Busy), 32'd1);

        while (accepted < N && guard < GUARD) begin
            guard++;
            if (v.gap && phase) begin
                bus.PixValid = 1'b0;
            end else begin
                bus.PixValid = 1'b1;
                bus.CurPixel = 8'(int'(v.cur) + int'(v.step) * accepted);
                bus.RefPixel = v.ref_;
            end
            phase = ~phase;
            if (v.pulse && accepted == 5) begin
                bus.Start      = 1'b1;
                bus.CandRow    = 8'hEE;
                bus.CandColumn = 8'hEE;
            end else begin
                bus.Start = 1'b0;
            end
            if (accepted == N / 2) begin
                checkOutput("sadHeldInAccum", bus.SAD, lastSad);
                checkOutput("noValidInAccum", 32'(bus.SADValid), 32'd0);
            end
            if (bus.PixValid && bus.PixReady) accepted++;
            tick();
            cyc++;
            if (resetAfter >= 0 && accepted == resetAfter) begin
                bus.PixValid = 1'b0;
                Rst_n = 1'b0;
                #1;
                checkOutput("rstSad",      bus.SAD,                32'd0);
                checkOutput("rstRow",      32'(bus.SADRow),        32'd0);
                checkOutput("rstCol",      32'(bus.SADColumn),     32'd0);
                checkOutput("rstValid",    32'(bus.SADValid),      32'd0);
                checkOutput("rstPixReady", 32'(bus.PixReady),      32'd0);
                checkOutput("rstBusy",     32'(bus.Busy),          32'd0);
                sbQ.delete();
                lastSad = '0;
                @(negedge Clk);
                Rst_n = 1'b1;
                tick();
                return;
            end
        end
        bus.PixValid = 1'b0;
        bus.Start    = 1'b0;
        if (guard >= GUARD) begin
            checkOutput("streamTimeout", 32'(accepted), 32'(N));
        end
        checkOutput("validAfterLastPair", 32'(bus.SADValid), 32'd1);
        if (v.expLat > 0) checkOutput("latency", 32'(cyc), 32'(v.expLat));

        bus.SADReady = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            checkOutput("sadHeldInDone", bus.SAD, v.expSad);
            checkOutput("validHeldInDone", 32'(bus.SADValid), 32'd1);
            bus.Start = v.pulse;
            tick();
        end
        bus.SADReady = 1'b1;
        bus.Start    = v.pulse;
        tick();
        bus.SADReady = 1'b0;
        bus.Start    = 1'b0;
        checkOutput("validDropped", 32'(bus.SADValid), 32'd0);
        checkOutput("idleAfterAccept", 32'(bus.Busy), 32'd0);
        lastSad = v.expSad;
        if (v.pulse) begin
            tick();
            tick();
            checkOutput("startNotQueued", 32'(bus.Busy), 32'd0);
        end
    endtask

    initial begin
        vec_t rv;

        //          row    col    cur     ref     step  gap  hold pulse expSad  expLat
        tbl[0] = '{8'd3,  8'd5,  8'd10,  8'd7,   8'd0,  1'b0, 0, 1'b0, 32'd48,   17};
        tbl[1] = '{8'd3,  8'd5,  8'd10,  8'd7,   8'd0,  1'b1, 0, 1'b0, 32'd48,   0};
        tbl[2] = '{8'd1,  8'd2,  8'd0,   8'd255, 8'd0,  1'b0, 5, 1'b0, 32'd4080, 17};
        tbl[3] = '{8'd7,  8'd8,  8'd255, 8'd0,   8'd0,  1'b0, 2, 1'b1, 32'd4080, 17};
        tbl[4] = '{8'd20, 8'd21, 8'd10,  8'd7,   8'd0,  1'b0, 0, 1'b0, 32'd48,   17};
        tbl[5] = '{8'd22, 8'd23, 8'd77,  8'd77,  8'd0,  1'b0, 1, 1'b0, 32'd0,    17};

        bus.Start      = 1'b0;
        bus.CandRow    = '0;
        bus.CandColumn = '0;
        bus.PixValid   = 1'b0;
        bus.CurPixel   = '0;
        bus.RefPixel   = '0;
        bus.SADReady   = 1'b0;

        #2;
        checkOutput("resetSad",      bus.SAD,            32'd0);
        checkOutput("resetValid",    32'(bus.SADValid),  32'd0);
        checkOutput("resetPixReady", 32'(bus.PixReady),  32'd0);
        checkOutput("resetBusy",     32'(bus.Busy),      32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) applyStimulus(tbl[i], -1);

        rv = '{8'd3, 8'd5, 8'd10, 8'd7, 8'd0, 1'b0, 0, 1'b0, 32'd48, 0};
        applyStimulus(rv, 7);
        rv = '{8'd13, 8'd14, 8'd50, 8'd51, 8'd0, 1'b0, 0, 1'b0, 32'd16, 17};
        applyStimulus(rv, -1);

        for (int i = 4; i < 6; i++) applyStimulus(tbl[i], -1);

        rv = '{8'd30, 8'd31, 8'd100, 8'd150, 8'd10, 1'b1, 1, 1'b0, 32'd700, 0};
        applyStimulus(rv, -1);

        tick();
        checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
